// File: rtl/spi_boot_pkg.sv
// Shared constants for the SPI flash boot loader: FSM state encoding and
// the flash read command.
package spi_boot_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [7:0] READ_OPCODE = 8'h03;

    localparam logic [5:0] CMD_BITS  = 6'd8;
    localparam logic [5:0] ADDR_BITS = 6'd24;
    localparam logic [5:0] BYTE_BITS = 6'd8;

endpackage

// File: rtl/spi_boot_shifter.sv
// Mode-0 SPI clock divider and MSB-first shifter. A segment queued with start
// before the last falling edge of the current one continues the burst seamlessly.
module spi_boot_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  bit_count,
    input  logic [31:0] tx_data,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        done,
    output logic [7:0]  rx_data
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active_q, active_d;
    logic          sclk_q, sclk_d;
    logic [DW-1:0] div_q, div_d;
    logic [31:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_tx_q, pend_tx_d;
    logic [5:0]    pend_cnt_q, pend_cnt_d;

    always_comb begin
        active_d   = active_q;
        sclk_d     = sclk_q;
        div_d      = div_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        pend_d     = pend_q;
        pend_tx_d  = pend_tx_q;
        pend_cnt_d = pend_cnt_q;

        if (start) begin
            pend_d     = 1'b1;
            pend_tx_d  = tx_data;
            pend_cnt_d = bit_count;
        end

        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                tx_d     = tx_data;
                cnt_d    = bit_count;
                pend_d   = 1'b0;
                div_d    = '0;
                sclk_d   = 1'b0;
            end
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
                // Rising edge: MISO has been stable since the previous fall.
                rx_d  = {rx_q[6:0], miso};
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    done_d = 1'b1;
                end
            end else if (cnt_q != 6'd0) begin
                tx_d = {tx_q[30:0], 1'b0};
            end else if (start || pend_q) begin
                tx_d   = start ? tx_data : pend_tx_q;
                cnt_d  = start ? bit_count : pend_cnt_q;
                pend_d = 1'b0;
            end else begin
                active_d = 1'b0;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            sclk_q     <= 1'b0;
            div_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_tx_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            active_q   <= active_d;
            sclk_q     <= sclk_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            pend_tx_q  <= pend_tx_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = active_q & tx_q[31];
    assign done    = done_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/spi_boot_loader.sv
// Copies LOAD_WORDS little-endian 32-bit words from SPI flash (single READ
// burst) into SRAM, then releases the processor.
module spi_boot_loader #(
    parameter int          W_ADDR     = 16,
    parameter int          LOAD_WORDS = 65536,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CLK_DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [W_ADDR-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic [3:0]        ram_byte_en,
    output logic              boot_done,
    output logic              cpu_rst_n
);
    import spi_boot_pkg::*;

    // One extra bit lets LOAD_WORDS = 2^W_ADDR finish without wrapping.
    localparam logic [W_ADDR:0] LAST_WORD = (W_ADDR + 1)'(LOAD_WORDS - 1);

    logic [2:0]        state_q, state_d;
    logic              cs_n_q, cs_n_d;
    logic              ram_we_q, ram_we_d;
    logic [W_ADDR-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [W_ADDR:0]   word_cnt_q, word_cnt_d;
    logic              boot_done_q, boot_done_d;

    logic        sh_start;
    logic [5:0]  sh_bits;
    logic [31:0] sh_tx;
    logic        sh_sclk;
    logic        sh_mosi;
    logic        sh_done;
    logic [7:0]  sh_rx;

    spi_boot_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start     (sh_start),
        .bit_count (sh_bits),
        .tx_data   (sh_tx),
        .miso      (spi_miso),
        .sclk      (sh_sclk),
        .mosi      (sh_mosi),
        .done      (sh_done),
        .rx_data   (sh_rx)
    );

    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        boot_done_d = boot_done_q;
        sh_start    = 1'b0;
        sh_bits     = BYTE_BITS;
        sh_tx       = '0;

        case (state_q)
            ST_IDLE: begin
                state_d  = ST_CMD;
                cs_n_d   = 1'b0;
                sh_start = 1'b1;
                sh_bits  = CMD_BITS;
                sh_tx    = {READ_OPCODE, 24'h000000};
            end
            ST_CMD: begin
                if (sh_done) begin
                    state_d  = ST_ADDR;
                    sh_start = 1'b1;
                    sh_bits  = ADDR_BITS;
                    sh_tx    = {FLASH_BASE, 8'h00};
                end
            end
            ST_ADDR: begin
                if (sh_done) begin
                    state_d  = ST_DATA;
                    sh_start = 1'b1;
                end
            end
            ST_DATA: begin
                if (sh_done) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Queue the next byte now so SCLK never pauses across WRITE.
                    sh_start = !((byte_idx_q == 2'd3) && (word_cnt_q == LAST_WORD));
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = sh_rx;
                        2'd1: word_d[15:8]  = sh_rx;
                        2'd2: word_d[23:16] = sh_rx;
                        default: begin
                            state_d     = ST_WRITE;
                            ram_we_d    = 1'b1;
                            ram_wdata_d = {sh_rx, word_q};
                            ram_addr_d  = word_cnt_q[W_ADDR-1:0];
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == LAST_WORD) begin
                    state_d     = ST_DONE;
                    cs_n_d      = 1'b1;
                    boot_done_d = 1'b1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cs_n_q      <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            word_q      <= '0;
            byte_idx_q  <= '0;
            word_cnt_q  <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_n_q      <= cs_n_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            boot_done_q <= boot_done_d;
        end
    end

    // Gating with chip select parks SCLK low the moment DONE is entered.
    assign spi_cs_n    = cs_n_q;
    assign spi_sclk    = sh_sclk & ~cs_n_q;
    assign spi_mosi    = sh_mosi & ~cs_n_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_byte_en = {4{ram_we_q}};
    assign boot_done   = boot_done_q;
    assign cpu_rst_n   = boot_done_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: four configurations share one mode-0 flash model
// (byte n = n[7:0]) and a word RAM; SRAM writes are checked by a scoreboard.
module tb_spi_boot_loader;
    localparam int N = 4;
    localparam int          P_W    [N] = '{16, 16, 16, 4};
    localparam int          P_LW   [N] = '{4, 4, 4, 16};
    localparam logic [23:0] P_BASE [N] = '{24'h000000, 24'h000100, 24'h000000, 24'h000000};
    localparam int          P_DIV  [N] = '{2, 2, 1, 1};

    typedef struct {
        int          inst;
        int          addr;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        int          inst;
        int          lw;
        logic [31:0] exp_cmd;
        int          exp_rises;
        int          exp_period;
        int          exp_last;
    } case_t;

    logic           clk = 1'b0;
    logic [N-1:0]   rst_v;
    logic [N-1:0]   miso_v;
    logic           cs_n_w  [N];
    logic           sclk_w  [N];
    logic           mosi_w  [N];
    logic           we_w    [N];
    logic           done_w  [N];
    logic           cpurst_w[N];
    logic [3:0]     be_w    [N];
    logic [31:0]    wdata_w [N];
    logic [15:0]    addr_w  [N];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            logic [P_W[gi]-1:0] addr_l;
            spi_boot_loader #(
                .W_ADDR    (P_W[gi]),
                .LOAD_WORDS(P_LW[gi]),
                .FLASH_BASE(P_BASE[gi]),
                .CLK_DIV   (P_DIV[gi])
            ) u_dut (
                .clk        (clk),
                .rst        (rst_v[gi]),
                .spi_cs_n   (cs_n_w[gi]),
                .spi_sclk   (sclk_w[gi]),
                .spi_mosi   (mosi_w[gi]),
                .spi_miso   (miso_v[gi]),
                .ram_addr   (addr_l),
                .ram_wdata  (wdata_w[gi]),
                .ram_we     (we_w[gi]),
                .ram_byte_en(be_w[gi]),
                .boot_done  (done_w[gi]),
                .cpu_rst_n  (cpurst_w[gi])
            );
            assign addr_w[gi] = 16'(addr_l);
        end
    endgenerate

    int          checks, errors, cyc;
    sb_t         exp_q[$];
    case_t       cases[N];
    int          period[N];
    int          fl_bits[N];
    logic [31:0] fl_cmd[N];
    logic        prev_sclk[N];
    logic        prev_done[N];
    int          rises[N], last_rise[N], gap_err[N], edges[N];
    int          we_cnt[N], last_we_addr[N], done_rise[N];
    logic [31:0] mem[N][16];

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, exp);
        end
    endtask

    // One clock of observation: flash model, SCLK timing monitor, RAM + scoreboard.
    task automatic tick();
        int          j;
        logic [23:0] fa;
        sb_t         e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (cs_n_w[i]) begin
                fl_bits[i] = 0;
            end else begin
                if (sclk_w[i] && !prev_sclk[i]) begin
                    if (fl_bits[i] < 32) fl_cmd[i] = {fl_cmd[i][30:0], mosi_w[i]};
                    fl_bits[i]++;
                    rises[i]++;
                    if (last_rise[i] >= 0 && (cyc - last_rise[i]) != period[i]) gap_err[i]++;
                    last_rise[i] = cyc;
                end
                if (!sclk_w[i] && prev_sclk[i] && fl_bits[i] >= 32) begin
                    j  = fl_bits[i] - 32;
                    fa = fl_cmd[i][23:0] + 24'(j / 8);
                    miso_v[i] = fa[7 - (j % 8)];
                end
            end
            if (sclk_w[i] != prev_sclk[i]) edges[i]++;
            prev_sclk[i] = sclk_w[i];
            if (done_w[i] && !prev_done[i]) done_rise[i]++;
            prev_done[i] = done_w[i];
            if (we_w[i]) begin
                we_cnt[i]++;
                last_we_addr[i] = int'(addr_w[i]);
                if (addr_w[i] < 16'd16) mem[i][addr_w[i][3:0]] = wdata_w[i];
                $display("write inst%0d addr=%0h data=%h be=%h", i, addr_w[i], wdata_w[i], be_w[i]);
                if (exp_q.size() == 0) begin
                    chk("sb_extra_write", i, 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst", i, 64'(i), 64'(e.inst));
                    chk("sb_addr", i, 64'(addr_w[i]), 64'(e.addr));
                    chk("sb_data", i, 64'(wdata_w[i]), 64'(e.data));
                    chk("sb_byte_en", i, 64'(be_w[i]), 64'hf);
                end
            end
        end
    endtask

    task automatic start_load(input int i);
        logic [23:0] a;
        logic [31:0] d;
        for (int w = 0; w < P_LW[i]; w++) begin
            for (int k = 0; k < 4; k++) begin
                a = P_BASE[i] + 24'(4 * w + k);
                d[8*k +: 8] = a[7:0];
            end
            exp_q.push_back('{inst: i, addr: w, data: d});
        end
        rises[i] = 0; last_rise[i] = -1; gap_err[i] = 0;
        we_cnt[i] = 0; done_rise[i] = 0; fl_bits[i] = 0;
        rst_v[i] = 1'b0;
        tick();
        chk("cs_n_low_after_idle", i, 64'(cs_n_w[i]), 64'd0);
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (!done_w[i] && n < 20000) begin
            tick();
            n++;
        end
        chk("done_reached", i, 64'(done_w[i]), 64'd1);
        chk("cs_n_high_at_done", i, 64'(cs_n_w[i]), 64'd1);
        chk("cpu_rst_n_at_done", i, 64'(cpurst_w[i]), 64'd1);
    endtask

    initial begin
        logic [31:0] lit[4];
        int          i, n, e0, w0;
        checks = 0; errors = 0; cyc = 0;
        rst_v = '1; miso_v = '0;
        for (int k = 0; k < N; k++) begin
            fl_bits[k] = 0; fl_cmd[k] = '0; prev_sclk[k] = 1'b0; prev_done[k] = 1'b0;
            rises[k] = 0; last_rise[k] = -1; gap_err[k] = 0; edges[k] = 0;
            we_cnt[k] = 0; last_we_addr[k] = -1; done_rise[k] = 0;
            for (int w = 0; w < 16; w++) mem[k][w] = '0;
        end
        lit = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c};
        cases[0] = '{inst: 0, lw: 4,  exp_cmd: 32'h03000000, exp_rises: 160, exp_period: 4, exp_last: 3};
        cases[1] = '{inst: 1, lw: 4,  exp_cmd: 32'h03000100, exp_rises: 160, exp_period: 4, exp_last: 3};
        cases[2] = '{inst: 2, lw: 4,  exp_cmd: 32'h03000000, exp_rises: 160, exp_period: 2, exp_last: 3};
        cases[3] = '{inst: 3, lw: 16, exp_cmd: 32'h03000000, exp_rises: 544, exp_period: 2, exp_last: 15};
        for (int c = 0; c < N; c++) period[cases[c].inst] = cases[c].exp_period;

        repeat (3) tick();
        for (int k = 0; k < N; k++) begin
            chk("reset_outputs", k,
                64'({cs_n_w[k], sclk_w[k], mosi_w[k], we_w[k], done_w[k], cpurst_w[k],
                     be_w[k], addr_w[k], wdata_w[k]}),
                64'({1'b1, 57'd0}));
        end

        for (int c = 0; c < N; c++) begin
            i = cases[c].inst;
            start_load(i);
            wait_done(i);
            chk("cmd_stream", i, 64'(fl_cmd[i]), 64'(cases[c].exp_cmd));
            chk("sclk_rise_count", i, 64'(rises[i]), 64'(cases[c].exp_rises));
            chk("sclk_gap", i, 64'(gap_err[i]), 64'd0);
            chk("write_count", i, 64'(we_cnt[i]), 64'(cases[c].lw));
            chk("last_write_addr", i, 64'(last_we_addr[i]), 64'(cases[c].exp_last));
            tick(); tick();
            chk("done_rises_once", i, 64'(done_rise[i]), 64'd1);
            chk("sb_drained", i, 64'(exp_q.size()), 64'd0);
        end

        for (int w = 0; w < 4; w++) chk("ram_word_inst0", w, 64'(mem[0][w]), 64'(lit[w]));
        chk("ram_word0_offset", 1, 64'(mem[1][0]), 64'h03020100);

        e0 = edges[0]; w0 = we_cnt[0];
        repeat (1000) tick();
        chk("silent_sclk", 0, 64'(edges[0] - e0), 64'd0);
        chk("silent_we", 0, 64'(we_cnt[0] - w0), 64'd0);
        chk("silent_cs_n", 0, 64'(cs_n_w[0]), 64'd1);

        rst_v[0] = 1'b1;
        tick(); tick();
        for (int w = 0; w < 16; w++) mem[0][w] = '0;
        start_load(0);
        n = 0;
        while (fl_bits[0] < 75 && n < 5000) begin
            tick();
            n++;
        end
        chk("reach_byte6", 0, 64'(fl_bits[0] >= 75), 64'd1);
        rst_v[0] = 1'b1;
        tick();
        chk("abort_cs_n", 0, 64'(cs_n_w[0]), 64'd1);
        chk("abort_done", 0, 64'(done_w[0]), 64'd0);
        chk("abort_sclk", 0, 64'(sclk_w[0]), 64'd0);
        exp_q.delete();
        tick();
        for (int w = 0; w < 16; w++) mem[0][w] = '0;
        start_load(0);
        wait_done(0);
        chk("reload_cmd", 0, 64'(fl_cmd[0]), 64'h03000000);
        chk("reload_rises", 0, 64'(rises[0]), 64'd160);
        chk("reload_sb_drained", 0, 64'(exp_q.size()), 64'd0);
        for (int w = 0; w < 4; w++) chk("reload_ram_word", w, 64'(mem[0][w]), 64'(lit[w]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
